// File: rtl/exp4_unidade_controle_pkg.sv
// Shared state codes and widths for the Experiment 4 memory-game control unit.
// EXP4_TIMEOUT_EN selects the move-timeout variant of the control unit.
package exp4_unidade_controle_pkg;

    localparam int ESTADO_W              = 4;
    localparam int TIMEOUT_W             = 13;
    localparam int TIMEOUT_CICLOS_PADRAO = 5000;

    // Codes are shown on the 7-seg debug display, so they are fixed by hand.
    typedef enum logic [ESTADO_W-1:0] {
        INICIAL       = 4'b0000,
        PREPARACAO    = 4'b0001,
        ESPERA_JOGADA = 4'b0010,
        REGISTRA      = 4'b0100,
        COMPARACAO    = 4'b0101,
        PROXIMO       = 4'b0110,
        FIM_ACERTOU   = 4'b1010,
        FIM_ERROU     = 4'b1110,
        FIM_TIMEOUT   = 4'b1101
    } estado_t;

endpackage

// File: rtl/contador_timeout.sv
// Cycle counter that flags when a move has been awaited for FIM_VALOR clocks.
// Only instantiated when EXP4_TIMEOUT_EN is defined.
module contador_timeout
    import exp4_unidade_controle_pkg::*;
#(
    parameter int W         = TIMEOUT_W,
    parameter int FIM_VALOR = TIMEOUT_CICLOS_PADRAO
) (
    input  logic clock,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic fim
);

    localparam logic [W-1:0] ULTIMO = W'(FIM_VALOR - 1);

    logic [W-1:0] cnt;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + 1'b1;
        end
    end

    // Asserted during the last allowed waiting cycle.
    assign fim = en && (cnt == ULTIMO);

endmodule

// File: rtl/exp4_unidade_controle.sv
// Moore control unit for the Experiment 4 memory game: walks 16 ROM positions,
// registering and comparing one move each. EXP4_TIMEOUT_EN adds a move timeout.
module exp4_unidade_controle
    import exp4_unidade_controle_pkg::*;
`ifdef EXP4_TIMEOUT_EN
#(
    parameter int TIMEOUT_CICLOS = TIMEOUT_CICLOS_PADRAO
)
`endif
(
    input  logic                clock,
    input  logic                reset,
    input  logic                iniciar,
    input  logic                jogada_feita,
    input  logic                igual,
    input  logic                fimC,
    output logic                zeraC,
    output logic                contaC,
    output logic                zeraR,
    output logic                registraR,
    output logic                pronto,
    output logic                acertou,
    output logic                errou,
    output logic [ESTADO_W-1:0] db_estado
`ifdef EXP4_TIMEOUT_EN
    ,
    output logic                db_timeout
`endif
);

    estado_t estado;
    estado_t prox_estado;
    logic    expirou;

`ifdef EXP4_TIMEOUT_EN
    contador_timeout #(
        .W         (TIMEOUT_W),
        .FIM_VALOR (TIMEOUT_CICLOS)
    ) u_contador_timeout (
        .clock (clock),
        .reset (reset),
        .clr   (estado != ESPERA_JOGADA),
        .en    (estado == ESPERA_JOGADA),
        .fim   (expirou)
    );
`else
    assign expirou = 1'b0;
`endif

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            estado <= INICIAL;
        end else begin
            estado <= prox_estado;
        end
    end

    // A move arriving in the last waiting cycle takes priority over the timeout.
    always_comb begin
        prox_estado = INICIAL;
        case (estado)
            INICIAL:       prox_estado = iniciar ? PREPARACAO : INICIAL;
            PREPARACAO:    prox_estado = ESPERA_JOGADA;
            ESPERA_JOGADA: begin
                if (jogada_feita) begin
                    prox_estado = REGISTRA;
                end else if (expirou) begin
                    prox_estado = FIM_TIMEOUT;
                end else begin
                    prox_estado = ESPERA_JOGADA;
                end
            end
            REGISTRA:      prox_estado = COMPARACAO;
            COMPARACAO: begin
                if (!igual) begin
                    prox_estado = FIM_ERROU;
                end else if (fimC) begin
                    prox_estado = FIM_ACERTOU;
                end else begin
                    prox_estado = PROXIMO;
                end
            end
            PROXIMO:       prox_estado = ESPERA_JOGADA;
            FIM_ACERTOU:   prox_estado = iniciar ? PREPARACAO : FIM_ACERTOU;
            FIM_ERROU:     prox_estado = iniciar ? PREPARACAO : FIM_ERROU;
            FIM_TIMEOUT:   prox_estado = iniciar ? PREPARACAO : FIM_TIMEOUT;
            default:       prox_estado = INICIAL;
        endcase
    end

    // Outputs depend on the registered state only.
    always_comb begin
        zeraC     = 1'b0;
        contaC    = 1'b0;
        zeraR     = 1'b0;
        registraR = 1'b0;
        pronto    = 1'b0;
        acertou   = 1'b0;
        errou     = 1'b0;
        case (estado)
            PREPARACAO: begin
                zeraC = 1'b1;
                zeraR = 1'b1;
            end
            REGISTRA:    registraR = 1'b1;
            PROXIMO:     contaC    = 1'b1;
            FIM_ACERTOU: begin
                pronto  = 1'b1;
                acertou = 1'b1;
            end
            FIM_ERROU, FIM_TIMEOUT: begin
                pronto = 1'b1;
                errou  = 1'b1;
            end
            default: ;
        endcase
    end

    assign db_estado = estado;

`ifdef EXP4_TIMEOUT_EN
    assign db_timeout = (estado == FIM_TIMEOUT);
`endif

endmodule

// File: tb/tb_exp4_unidade_controle.sv
// Directed bench for exp4_unidade_controle; round results go through an expected queue
// checked by a monitor on each rising edge of pronto. Covers EXP4_TIMEOUT_EN when defined.
module tb_exp4_unidade_controle;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       iniciar = 1'b0;
    logic       jogada_feita = 1'b0;
    logic       igual = 1'b0;
    logic       fimC = 1'b0;
    logic       zeraC, contaC, zeraR, registraR, pronto, acertou, errou;
    logic [3:0] db_estado;
    logic       to_bit;

    int n_checks = 0;
    int n_fail   = 0;

    // {timeout, acertou, errou, estado[3:0], contaC pulses[7:0], registraR pulses[7:0]}
    logic [22:0] exp_q[$];

`ifdef EXP4_TIMEOUT_EN
    logic db_timeout;
    exp4_unidade_controle #(.TIMEOUT_CICLOS(8)) dut (
        .clock(clock), .reset(reset), .iniciar(iniciar), .jogada_feita(jogada_feita),
        .igual(igual), .fimC(fimC), .zeraC(zeraC), .contaC(contaC), .zeraR(zeraR),
        .registraR(registraR), .pronto(pronto), .acertou(acertou), .errou(errou),
        .db_estado(db_estado), .db_timeout(db_timeout)
    );
    assign to_bit = db_timeout;
`else
    exp4_unidade_controle dut (
        .clock(clock), .reset(reset), .iniciar(iniciar), .jogada_feita(jogada_feita),
        .igual(igual), .fimC(fimC), .zeraC(zeraC), .contaC(contaC), .zeraR(zeraR),
        .registraR(registraR), .pronto(pronto), .acertou(acertou), .errou(errou),
        .db_estado(db_estado)
    );
    assign to_bit = 1'b0;
`endif

    // ---------------- clock / watchdog ----------------
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- helpers ----------------
    task automatic chk(input string nome, input logic [31:0] atual, input logic [31:0] esperado);
        n_checks++;
        if (atual !== esperado) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nome, atual, esperado, $time);
        end
    endtask

    function automatic logic [22:0] res(input bit to, input bit ac, input bit er,
                                        input logic [3:0] est, input int nc, input int nr);
        return {to, ac, er, est, 8'(nc), 8'(nr)};
    endfunction

    // ---------------- monitor / scoreboard ----------------
    int   cnt_conta = 0;
    int   cnt_reg   = 0;
    logic pronto_q  = 1'b0;
    logic [22:0] esp;

    always @(negedge clock) begin
        if (!reset) begin
            cnt_conta = 0;
            cnt_reg   = 0;
            pronto_q  = 1'b0;
        end else begin
            if (zeraC) begin
                cnt_conta = 0;
                cnt_reg   = 0;
            end
            if (contaC)    cnt_conta++;
            if (registraR) cnt_reg++;
            if (pronto && !pronto_q) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL round_result: round ended with estado %0h but none expected", db_estado);
                end else begin
                    esp = exp_q.pop_front();
                    chk("round_result", {to_bit, acertou, errou, db_estado, 8'(cnt_conta), 8'(cnt_reg)}, esp);
                end
            end
            pronto_q = pronto;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic wait_state(input logic [3:0] alvo, input int max, input string nome);
        int i = 0;
        while (db_estado !== alvo && i < max) begin
            @(negedge clock);
            i++;
        end
        chk(nome, db_estado, alvo);
    endtask

    task automatic start_round();
        @(negedge clock);
        iniciar = 1'b1;
        @(negedge clock);
        iniciar = 1'b0;
        chk("prep_state", db_estado, 4'b0001);
        chk("prep_zera", {zeraC, zeraR}, 2'b11);
        @(negedge clock);
        chk("espera_state", db_estado, 4'b0010);
        chk("prep_one_cycle", {zeraC, zeraR}, 2'b00);
    endtask

    task automatic play_move(input bit igual_v, input bit fim_v, input logic [3:0] exp_state);
        wait_state(4'b0010, 50, "wait_espera");
        igual        = igual_v;
        fimC         = fim_v;
        jogada_feita = 1'b1;
        @(negedge clock);
        jogada_feita = 1'b0;
        @(negedge clock);
        @(negedge clock);
        chk("move_result_state", db_estado, exp_state);
    endtask

    // Move with extra jogada_feita pulses during REGISTRA and PROXIMO.
    task automatic play_noisy_move();
        wait_state(4'b0010, 50, "wait_espera");
        igual        = 1'b1;
        fimC         = 1'b0;
        jogada_feita = 1'b1;
        @(negedge clock);
        chk("noisy_registra", db_estado, 4'b0100);
        @(negedge clock);
        jogada_feita = 1'b0;
        @(negedge clock);
        chk("noisy_proximo", db_estado, 4'b0110);
        jogada_feita = 1'b1;
        @(negedge clock);
        jogada_feita = 1'b0;
        chk("noisy_back_espera", db_estado, 4'b0010);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        #2 reset = 1'b0;
        #1;
        chk("reset_outputs", {zeraC, contaC, zeraR, registraR, pronto, acertou, errou, db_estado}, 11'd0);
        repeat (2) @(negedge clock);
        reset = 1'b1;

        // Reset asserted mid-COMPARACAO
        start_round();
        play_move(1'b1, 1'b0, 4'b0110);
        wait_state(4'b0010, 50, "wait_espera");
        igual        = 1'b1;
        jogada_feita = 1'b1;
        @(negedge clock);
        jogada_feita = 1'b0;
        @(negedge clock);
        chk("in_comparacao", db_estado, 4'b0101);
        #2 reset = 1'b0;
        #1;
        chk("async_reset_outputs", {zeraC, contaC, zeraR, registraR, pronto, acertou, errou, db_estado}, 11'd0);
        @(negedge clock);
        reset = 1'b1;

        // 16 correct moves, with ignored pulses on move 2
        exp_q.push_back(res(0, 1, 0, 4'b1010, 15, 16));
        start_round();
        play_move(1'b1, 1'b0, 4'b0110);
        play_noisy_move();
        for (int m = 3; m <= 15; m++) play_move(1'b1, 1'b0, 4'b0110);
        play_move(1'b1, 1'b1, 4'b1010);
        chk("acertou_flags", {pronto, acertou, errou}, 3'b110);

        // Mismatch on the 3rd move
        exp_q.push_back(res(0, 0, 1, 4'b1110, 2, 3));
        start_round();
        play_move(1'b1, 1'b0, 4'b0110);
        play_move(1'b1, 1'b0, 4'b0110);
        play_move(1'b0, 1'b0, 4'b1110);
        chk("errou_flags", {pronto, acertou, errou}, 3'b101);

        // Restart from FIM_ERROU, short round ending on fimC
        exp_q.push_back(res(0, 1, 0, 4'b1010, 1, 2));
        start_round();
        play_move(1'b1, 1'b0, 4'b0110);
        play_move(1'b1, 1'b1, 4'b1010);

`ifdef EXP4_TIMEOUT_EN
        // No move: timeout after 8 cycles in ESPERA_JOGADA
        exp_q.push_back(res(1, 0, 1, 4'b1101, 0, 0));
        start_round();
        begin
            int k = 0;
            while (db_estado === 4'b0010 && k < 100) begin
                k++;
                @(negedge clock);
            end
            chk("timeout_cycles", k, 8);
        end
        chk("timeout_state", db_estado, 4'b1101);
        chk("timeout_flags", {pronto, errou, db_timeout}, 3'b111);

        // Move in the 8th waiting cycle wins over the timeout
        exp_q.push_back(res(0, 0, 1, 4'b1110, 0, 1));
        start_round();
        repeat (7) @(negedge clock);
        chk("last_wait_cycle", db_estado, 4'b0010);
        igual        = 1'b0;
        fimC         = 1'b0;
        jogada_feita = 1'b1;
        @(negedge clock);
        jogada_feita = 1'b0;
        chk("late_move_registra", db_estado, 4'b0100);
        @(negedge clock);
        @(negedge clock);
        chk("late_move_result", db_estado, 4'b1110);
        chk("late_move_no_timeout", db_timeout, 1'b0);
`else
        // Without timeout, ESPERA_JOGADA waits indefinitely
        exp_q.push_back(res(0, 0, 1, 4'b1110, 0, 1));
        start_round();
        repeat (60) @(negedge clock);
        chk("wait_forever", db_estado, 4'b0010);
        play_move(1'b0, 1'b0, 4'b1110);
`endif

        repeat (3) @(negedge clock);
        chk("queue_empty", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
